// File: rtl/hold_window_counter_if.sv
// hold_window_counter_if: control inputs and count/status outputs of hold_window_counter
interface hold_window_counter_if #(
    parameter int WIDTH = 4
);
    logic             clr;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             ready;
    logic             tc;
    logic             wrap_pulse;

    modport master (output clr, en, load, load_val, input count, ready, tc, wrap_pulse);
    modport slave  (input clr, en, load, load_val, output count, ready, tc, wrap_pulse);
endinterface

// File: rtl/hold_window_counter.sv
// hold_window_counter: up-counter forced to 0 for HOLD_CYCLES edges after reset/clr, then counts with load/wrap/tc
// Optional embedded assertions: define HOLD_WINDOW_COUNTER_SVA_EN.
module hold_window_counter #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int MAX_VAL     = 2**WIDTH-1
) (
    input logic                clk,
    input logic                rst_n,
    hold_window_counter_if.slave bus
);
    typedef enum logic {S_HOLD, S_RUN} state_t;

    localparam bit               HAS_HOLD  = (HOLD_CYCLES != 0);
    localparam state_t           S_INIT    = HAS_HOLD ? S_HOLD : S_RUN;
    localparam logic [WIDTH-1:0] MAX       = WIDTH'(MAX_VAL);
    localparam logic [7:0]       HOLD_LAST = 8'(HAS_HOLD ? HOLD_CYCLES - 1 : 0);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [7:0]       r_hold_cnt, w_hold_nxt;
    logic             r_ready, r_wrap, w_wrap_nxt;

    // state register plus registered count/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_INIT;
            r_count    <= '0;
            r_hold_cnt <= '0;
            r_ready    <= !HAS_HOLD;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_ready    <= (w_state_nxt == S_RUN);
            r_wrap     <= w_wrap_nxt;
        end
    end

    // HOLD leaves on the last window edge unless clr restarts it; clr in RUN re-enters HOLD when a window exists
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_HOLD)
            w_state_nxt = (!bus.clr && r_hold_cnt == HOLD_LAST) ? S_RUN : S_HOLD;
        else if (bus.clr && HAS_HOLD)
            w_state_nxt = S_HOLD;
    end

    // next count, window counter and wrap flag; priority clr > load > en, compare before increment
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        w_hold_nxt  = '0;
        if (r_state == S_HOLD) begin
            w_count_nxt = '0;
            w_hold_nxt  = (bus.clr || w_state_nxt == S_RUN) ? 8'd0 : r_hold_cnt + 8'd1;
        end else if (bus.clr) begin
            w_count_nxt = '0;
        end else if (bus.load) begin
            w_count_nxt = (bus.load_val > MAX) ? MAX : bus.load_val;
        end else if (bus.en) begin
            w_wrap_nxt  = (r_count == MAX);
            w_count_nxt = w_wrap_nxt ? '0 : r_count + 1'b1;
        end
    end

    assign bus.count      = r_count;
    assign bus.ready      = r_ready;
    assign bus.wrap_pulse = r_wrap;
    assign bus.tc         = r_ready && (r_count == MAX);

`ifdef HOLD_WINDOW_COUNTER_SVA_EN
    a_not_ready_zero: assert property (@(posedge clk) disable iff (!rst_n)
        !r_ready |-> r_count == '0) else $error("a_not_ready_zero");
    a_wrap_from_max: assert property (@(posedge clk) disable iff (!rst_n)
        r_wrap |-> r_count == '0 && $past(r_count) == MAX) else $error("a_wrap_from_max");
    a_ready_rise: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(r_ready) |-> $past(!r_ready, 1)) else $error("a_ready_rise");
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= MAX) else $error("a_count_bound");
`endif
endmodule

// File: tb/tb_hold_window_counter.sv
// tb_hold_window_counter: three instances driven in lockstep, checked against a behavioural model
module tb_hold_window_counter;
    localparam int HC0 = 2, MV0 = 15;
    localparam int HC1 = 3, MV1 = 9;
    localparam int HC2 = 0, MV2 = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0, en = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    int         errors = 0, checks = 0;

    int m_count[3];
    int m_since[3];
    bit m_ready[3];
    bit m_wrap[3];

    hold_window_counter_if #(.WIDTH(4)) if0 ();
    hold_window_counter_if #(.WIDTH(4)) if1 ();
    hold_window_counter_if #(.WIDTH(4)) if2 ();

    assign if0.clr = clr;  assign if0.en = en;  assign if0.load = load;  assign if0.load_val = load_val;
    assign if1.clr = clr;  assign if1.en = en;  assign if1.load = load;  assign if1.load_val = load_val;
    assign if2.clr = clr;  assign if2.en = en;  assign if2.load = load;  assign if2.load_val = load_val;

    hold_window_counter #(.WIDTH(4), .HOLD_CYCLES(HC0), .MAX_VAL(MV0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    hold_window_counter #(.WIDTH(4), .HOLD_CYCLES(HC1), .MAX_VAL(MV1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    hold_window_counter #(.WIDTH(4), .HOLD_CYCLES(HC2), .MAX_VAL(MV2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    always #5 clk = ~clk;

    function automatic int hc(int k);
        return k == 0 ? HC0 : k == 1 ? HC1 : HC2;
    endfunction

    function automatic int mv(int k);
        return k == 0 ? MV0 : k == 1 ? MV1 : MV2;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_count[k] = 0;
            m_since[k] = 0;
            m_ready[k] = (hc(k) == 0);
            m_wrap[k]  = 0;
        end
    endtask

    // one clock edge of the specified behaviour, using the inputs currently applied
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (!m_ready[k]) begin
                m_since[k] = clr ? 0 : m_since[k] + 1;
                m_ready[k] = (m_since[k] >= hc(k));
                m_count[k] = 0;
                m_wrap[k]  = 0;
            end else if (clr) begin
                m_count[k] = 0;
                m_wrap[k]  = 0;
                if (hc(k) > 0) begin
                    m_ready[k] = 0;
                    m_since[k] = 0;
                end
            end else if (load) begin
                m_count[k] = (int'(load_val) > mv(k)) ? mv(k) : int'(load_val);
                m_wrap[k]  = 0;
            end else if (en) begin
                m_wrap[k]  = (m_count[k] == mv(k));
                m_count[k] = m_wrap[k] ? 0 : m_count[k] + 1;
            end else begin
                m_wrap[k] = 0;
            end
        end
    endtask

    task automatic check_dut(input int k, input logic [3:0] c, input logic r, input logic t, input logic w);
        chk($sformatf("u%0d.count", k), int'(c), m_count[k]);
        chk($sformatf("u%0d.ready", k), int'(r), int'(m_ready[k]));
        chk($sformatf("u%0d.tc", k), int'(t), int'(m_ready[k] && m_count[k] == mv(k)));
        chk($sformatf("u%0d.wrap_pulse", k), int'(w), int'(m_wrap[k]));
    endtask

    task automatic check_all();
        check_dut(0, if0.count, if0.ready, if0.tc, if0.wrap_pulse);
        check_dut(1, if1.count, if1.ready, if1.tc, if1.wrap_pulse);
        check_dut(2, if2.count, if2.ready, if2.tc, if2.wrap_pulse);
    endtask

    // called at a negedge: apply inputs, advance one posedge, check at the next negedge
    task automatic cycle(input bit c, input bit e, input bit l, input logic [3:0] v);
        clr = c; en = e; load = l; load_val = v;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // asynchronous reset asserted between edges, checked before the next posedge
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 4'd0);
        chk("plan_u0_count_after_hold", int'(if0.count), 2);
        chk("plan_u2_count_no_hold", int'(if2.count), 4);
        cycle(0, 0, 1, 4'd14);
        chk("plan_u1_load_clamped", int'(if1.count), 9);
        cycle(0, 1, 0, 4'd0);
        chk("plan_u0_tc_at_15", int'(if0.tc), 1);
        cycle(0, 1, 0, 4'd0);
        chk("plan_u0_wrap", int'(if0.wrap_pulse), 1);
        cycle(0, 1, 0, 4'd0);
        chk("plan_u0_wrap_one_cycle", int'(if0.wrap_pulse), 0);
        cycle(0, 0, 1, 4'd7);
        cycle(1, 1, 1, 4'd3);
        chk("plan_u0_clr_wins", int'(if0.count), 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 4'd0);
        cycle(0, 0, 1, 4'd5);
        async_reset();
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 4'd0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hold_window_counter.md
Name: hold_window_counter

Overview:
- Free-running up-counter that produces the `counter` value observed by the post-reset assertion checkers.
- After reset release, or after a synchronous clear, the count is forced to 0 for a programmable quiet window.
- After the window it counts on enable, with load, wrap and terminal-count signalling.
- Sits directly upstream of the reset/counter property checkers; its output feeds them one-to-one.

Parameters:
- WIDTH, 4: counter width in bits.
- HOLD_CYCLES, 2: number of clock edges `count` is forced to 0 after reset release or clr. Legal range 0..255.
- MAX_VAL, 2**WIDTH-1: terminal value; the count wraps from MAX_VAL to 0. Must be <= 2**WIDTH-1.

Ports:
- clk  input  1  clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset; asserted low, released synchronously by the environment.
- clr  input  1  synchronous clear; restarts the hold window.
- en  input  1  count enable, honoured in RUN only.
- load  input  1  synchronous load, honoured in RUN only.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count, registered.
- ready  output  1  high while in RUN, registered.
- tc  output  1  combinational: ready && (count == MAX_VAL).
- wrap_pulse  output  1  registered, high for exactly one cycle after a MAX_VAL->0 wrap.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - count=0, ready=0, wrap_pulse=0, hold_cnt=0.
  - State = HOLD, or RUN with ready=1 when HOLD_CYCLES==0.
- States: HOLD, RUN.
- HOLD:
  - count is held at 0; en and load are ignored.
  - hold_cnt increments each edge.
  - On the edge where hold_cnt==HOLD_CYCLES-1: go to RUN, ready<=1.
  - Result: ready rises at the HOLD_CYCLES-th posedge after rst_n release.
- clr in HOLD: hold_cnt<=0; the window restarts from the next edge.
- RUN, per edge, priority clr > load > en:
  - clr: count<=0, hold_cnt<=0, ready<=0, go to HOLD. If HOLD_CYCLES==0, count<=0 and stay in RUN.
  - load: count<=min(load_val, MAX_VAL); no wrap_pulse.
  - en with count==MAX_VAL: count<=0, wrap_pulse<=1.
  - en otherwise: count<=count+1.
  - none of the above: count holds.
- wrap_pulse is 0 on every edge other than a wrap edge; back-to-back wraps are impossible unless MAX_VAL==0.
  - With MAX_VAL==0: every enabled edge is a wrap, and wrap_pulse stays high while en is high.
- Arithmetic: the increment is WIDTH bits. No overflow beyond MAX_VAL is possible, because the compare happens before the increment.
- Simultaneous events:
  - clr with load/en: clr wins.
  - load with en: load wins, with no increment.
  - rst_n low overrides everything, including mid-window and mid-count.
- Guarantee to downstream checkers: for HOLD_CYCLES edges after any reset release or clr, count==0 on every sampled edge.

Optional Feature:
- Macro: HOLD_WINDOW_COUNTER_SVA_EN.
- When defined, embedded concurrent assertions are compiled in, clocked on posedge clk, disable iff (!rst_n):
  - (a) !ready |-> count==0.
  - (b) wrap_pulse |-> count==0 && $past(count)==MAX_VAL.
  - (c) $rose(ready) |-> $past(!ready, 1).
  - (d) count <= MAX_VAL always.
- Each assertion fails with $error naming the property.
- When undefined: no assertion code is present; functional behaviour is identical.

Test Plan:
- Defaults, hold rst_n low 2 cycles then release, en=1 constant -> count=0 and ready=0 at posedges 1-2 after release; ready=1 after posedge 2; count=1,2,3 on the following edges.
- Defaults, RUN, load=1 with load_val=14, then en=1 for 2 edges -> count=14, 15 (tc=1), then 0 with wrap_pulse=1 for one cycle only.
- Instance MAX_VAL=9, RUN, load_val=12 -> count=9, tc=1; next en edge -> count=0, wrap_pulse=1.
- Defaults, RUN at count=7, clr=1 with en=1 and load=1 on the same edge -> count=0, ready=0 for 2 edges, then counting resumes 1,2...
- Defaults, count=5, drive rst_n low between clock edges -> count=0 and ready=0 immediately, before the next posedge; after release the 2-cycle hold repeats.
- HOLD_CYCLES=0, release reset with en=1 -> ready=1 at reset; count=1 at the first posedge.
